// File: rtl/atm_keypad_entry_pkg.sv
// Shared types and constants for the ATM keypad front-end: entry state
// encoding, key codes and credential field widths.
package atm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACC     = 3'd1,
      ST_PIN     = 3'd2,
      ST_OTP     = 3'd3,
      ST_PRESENT = 3'd4,
      ST_LOCKED  = 3'd5
   } entry_state_e;

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CLEAR  = 4'hB;
   localparam logic [3:0] KEY_CANCEL = 4'hC;

   localparam int ACC_W   = 12;
   localparam int PIN_W   = 4;
   localparam int OTP_W   = 4;
   localparam int ACCUM_W = 14;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad/controller bus of atm_keypad_entry. master = keypad and ATM
// controller side, slave = the entry block.
interface atm_keypad_entry_if;
   logic                       key_valid;
   logic [3:0]                 key_code;
   logic                       auth_ok;
   logic                       auth_fail;
   logic [atm_pkg::ACC_W-1:0]  accNumber;
   logic [atm_pkg::PIN_W-1:0]  pin;
   logic [atm_pkg::OTP_W-1:0]  otp;
   logic                       cred_valid;
   logic                       entry_error;
   logic                       locked;
   logic [2:0]                 state_o;

   modport master (
      output key_valid, key_code, auth_ok, auth_fail,
      input  accNumber, pin, otp, cred_valid, entry_error, locked, state_o
   );

   modport slave (
      input  key_valid, key_code, auth_ok, auth_fail,
      output accNumber, pin, otp, cred_valid, entry_error, locked, state_o
   );
endinterface

// File: rtl/atm_keypad_entry_digit_accum.sv
// Decimal digit accumulator shared by all credential fields: value*10+d with
// a per-field digit limit. Clear and add in one cycle loads the digit alone.
module atm_digit_accum
   import atm_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_add,
   input  logic [3:0]         i_digit,
   input  logic [CNT_W-1:0]   i_limit,
   output logic [ACCUM_W-1:0] o_value,
   output logic [CNT_W-1:0]   o_count
);

   localparam logic [ACCUM_W-1:0] TEN = ACCUM_W'(10);

   logic [ACCUM_W-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACCUM_W-1:0] w_base;
   logic [CNT_W-1:0]   w_cnt_base;
   logic [ACCUM_W-1:0] w_mul;

   assign w_base     = i_clr ? '0 : r_acc;
   assign w_cnt_base = i_clr ? '0 : r_cnt;
   assign w_mul      = w_base * TEN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_add && (w_cnt_base < i_limit)) begin
         r_acc <= w_mul + {{(ACCUM_W-4){1'b0}}, i_digit};
         r_cnt <= w_cnt_base + CNT_W'(1);
      end else if (i_clr) begin
         r_acc <= '0;
         r_cnt <= '0;
      end
   end

   assign o_value = r_acc;
   assign o_count = r_cnt;

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry FSM: collects account/PIN/OTP digits, presents credentials,
// counts auth failures and locks out. OTP stage built only with ATM_OTP_STAGE_EN.
module atm_keypad_entry
   import atm_pkg::*;
#(
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 64,
   parameter int ACC_DIGITS  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   atm_keypad_entry_if.slave  bus
);

   localparam int CNT_W = 4;
   localparam int TW    = $clog2(LOCK_CYCLES);

   entry_state_e        r_state, w_next;
   logic [ACC_W-1:0]    r_acc_num;
   logic [PIN_W-1:0]    r_pin;
   logic                r_cv, r_err;
   logic [2:0]          r_fails;
   logic [TW-1:0]       r_timer;

   logic [ACCUM_W-1:0]  w_val;
   logic [CNT_W-1:0]    w_cnt, w_limit;
   logic [2:0]          w_fail_sum;
   logic w_dig, w_ent, w_clrk, w_can, w_fld_ok;
   logic w_clr, w_add, w_err, w_cv, w_lat_acc, w_lat_pin, w_zero;
   logic w_fail_inc, w_fail_clr, w_tload;

   assign w_dig      = bus.key_valid && is_digit(bus.key_code);
   assign w_ent      = bus.key_valid && (bus.key_code == KEY_ENTER);
   assign w_clrk     = bus.key_valid && (bus.key_code == KEY_CLEAR);
   assign w_can      = bus.key_valid && (bus.key_code == KEY_CANCEL);
   assign w_limit    = (r_state == ST_ACC) ? CNT_W'(ACC_DIGITS) : CNT_W'(2);
   assign w_fld_ok   = (w_cnt != '0) && (w_val <= ACCUM_W'(15));
   assign w_fail_sum = r_fails + 3'd1;

   atm_digit_accum #(.CNT_W(CNT_W)) u_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_clr),
      .i_add   (w_add),
      .i_digit (bus.key_code),
      .i_limit (w_limit),
      .o_value (w_val),
      .o_count (w_cnt)
   );

`ifdef ATM_OTP_STAGE_EN
   logic [OTP_W-1:0] r_otp;
   logic             w_lat_otp;
`endif

   always_comb begin
      w_next     = r_state;
      w_clr      = 1'b0;
      w_add      = 1'b0;
      w_err      = 1'b0;
      w_cv       = 1'b0;
      w_lat_acc  = 1'b0;
      w_lat_pin  = 1'b0;
      w_zero     = 1'b0;
      w_fail_inc = 1'b0;
      w_fail_clr = 1'b0;
      w_tload    = 1'b0;
`ifdef ATM_OTP_STAGE_EN
      w_lat_otp  = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_dig) begin
               w_clr  = 1'b1;
               w_add  = 1'b1;
               w_next = ST_ACC;
            end
         end
         ST_ACC, ST_PIN, ST_OTP: begin
            if (w_dig) begin
               w_add = 1'b1;
            end else if (w_clrk) begin
               w_clr = 1'b1;
            end else if (w_can) begin
               w_clr  = 1'b1;
               w_zero = 1'b1;
               w_next = ST_IDLE;
            end else if (w_ent) begin
               w_clr = 1'b1;
               if (r_state == ST_ACC) begin
                  if ((w_cnt != '0) && (w_val <= ACCUM_W'(4095))) begin
                     w_lat_acc = 1'b1;
                     w_next    = ST_PIN;
                  end else begin
                     w_err = 1'b1;
                  end
               end else if (!w_fld_ok) begin
                  w_err = 1'b1;
               end else if (r_state == ST_PIN) begin
                  w_lat_pin = 1'b1;
`ifdef ATM_OTP_STAGE_EN
                  w_next    = ST_OTP;
               end else begin
                  w_lat_otp = 1'b1;
                  w_next    = ST_PRESENT;
                  w_cv      = 1'b1;
`else
                  w_next    = ST_PRESENT;
                  w_cv      = 1'b1;
`endif
               end
            end
         end
         ST_PRESENT: begin
            // Leaving PRESENT by any route drops the held credentials.
            if (w_can) begin
               w_zero = 1'b1;
               w_next = ST_IDLE;
            end else if (bus.auth_fail) begin
               w_zero = 1'b1;
               if (w_fail_sum == 3'(MAX_TRIES)) begin
                  w_fail_clr = 1'b1;
                  w_tload    = 1'b1;
                  w_next     = ST_LOCKED;
               end else begin
                  w_fail_inc = 1'b1;
                  w_next     = ST_IDLE;
               end
            end else if (bus.auth_ok) begin
               w_fail_clr = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (r_timer == '0) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_acc_num <= '0;
         r_pin     <= '0;
         r_cv      <= 1'b0;
         r_err     <= 1'b0;
         r_fails   <= '0;
         r_timer   <= '0;
      end else begin
         r_state <= w_next;
         r_cv    <= w_cv;
         r_err   <= w_err;
         if (w_zero) begin
            r_acc_num <= '0;
            r_pin     <= '0;
         end else begin
            if (w_lat_acc) r_acc_num <= w_val[ACC_W-1:0];
            if (w_lat_pin) r_pin     <= w_val[PIN_W-1:0];
         end
         if (w_fail_clr)      r_fails <= '0;
         else if (w_fail_inc) r_fails <= w_fail_sum;
         if (w_tload)                                  r_timer <= TW'(LOCK_CYCLES - 1);
         else if (r_state == ST_LOCKED && r_timer != '0) r_timer <= r_timer - TW'(1);
      end
   end

`ifdef ATM_OTP_STAGE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_otp <= '0;
      else if (w_zero)    r_otp <= '0;
      else if (w_lat_otp) r_otp <= w_val[OTP_W-1:0];
   end
   assign bus.otp = r_otp;
`else
   assign bus.otp = '0;
`endif

   assign bus.accNumber   = r_acc_num;
   assign bus.pin         = r_pin;
   assign bus.cred_valid  = r_cv;
   assign bus.entry_error = r_err;
   assign bus.locked      = (r_state == ST_LOCKED);
   assign bus.state_o     = r_state;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed scenarios plus random key/auth traffic
// checked every cycle against a digit-queue model of the entry rules.
module tb_atm_keypad_entry;

   localparam int MAXT   = 3;
   localparam int LOCK   = 64;
   localparam int ACC_D  = 4;
`ifdef ATM_OTP_STAGE_EN
   localparam bit OTP_EN = 1'b1;
`else
   localparam bit OTP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   atm_keypad_entry_if bus();

   atm_keypad_entry #(.MAX_TRIES(MAXT), .LOCK_CYCLES(LOCK), .ACC_DIGITS(ACC_D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   // model: 0 idle,1 acc,2 pin,3 otp,4 present,5 locked
   int m_st, m_acc, m_pin, m_otp, m_fails, m_left;
   int m_dig[$];
   bit e_cv, e_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int qval();
      int v = 0;
      foreach (m_dig[i]) v = v * 10 + m_dig[i];
      return v;
   endfunction

   task automatic mreset();
      m_st = 0; m_acc = 0; m_pin = 0; m_otp = 0; m_fails = 0; m_left = 0;
      m_dig.delete(); e_cv = 0; e_err = 0;
   endtask

   task automatic mzero();
      m_acc = 0; m_pin = 0; m_otp = 0; m_dig.delete();
   endtask

   task automatic mstep(input bit kv, input int kc, input bit ok, input bit fl);
      int v, n;
      e_cv = 0; e_err = 0;
      case (m_st)
         0: if (kv && kc <= 9) begin m_dig.delete(); m_dig.push_back(kc); m_st = 1; end
         1, 2, 3: if (kv) begin
            if (kc <= 9) begin
               if (m_dig.size() < ((m_st == 1) ? ACC_D : 2)) m_dig.push_back(kc);
            end else if (kc == 11) m_dig.delete();
            else if (kc == 12) begin mzero(); m_st = 0; end
            else if (kc == 10) begin
               v = qval(); n = m_dig.size(); m_dig.delete();
               if (m_st == 1) begin
                  if (n > 0 && v <= 4095) begin m_acc = v; m_st = 2; end
                  else e_err = 1;
               end else if (n == 0 || v > 15) e_err = 1;
               else if (m_st == 2) begin
                  m_pin = v;
                  if (OTP_EN) m_st = 3;
                  else begin m_st = 4; e_cv = 1; end
               end else begin m_otp = v; m_st = 4; e_cv = 1; end
            end
         end
         4: begin
            if (kv && kc == 12) begin mzero(); m_st = 0; end
            else if (fl) begin
               mzero(); m_fails++;
               if (m_fails == MAXT) begin m_fails = 0; m_st = 5; m_left = LOCK; end
               else m_st = 0;
            end else if (ok) m_fails = 0;
         end
         5: begin
            m_left--;
            if (m_left == 0) m_st = 0;
         end
         default: ;
      endcase
   endtask

   task automatic cmp_all();
      chk("state", bus.state_o, m_st);
      chk("cred_valid", bus.cred_valid, e_cv);
      chk("entry_error", bus.entry_error, e_err);
      chk("locked", bus.locked, (m_st == 5));
      if (m_st != 5) begin
         chk("accNumber", bus.accNumber, m_acc);
         chk("pin", bus.pin, m_pin);
         chk("otp", bus.otp, m_otp);
      end
   endtask

   task automatic cyc(input bit kv, input int kc, input bit ok, input bit fl);
      bus.key_valid = kv;
      bus.key_code  = 4'(kc);
      bus.auth_ok   = ok;
      bus.auth_fail = fl;
      mstep(kv, kc, ok, fl);
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic key(input int kc);
      cyc(1, kc, 0, 0);
   endtask

   task automatic keynum(input int v);
      int d[$];
      do begin d.push_front(v % 10); v = v / 10; end while (v > 0);
      foreach (d[i]) key(d[i]);
      key(10);
   endtask

   task automatic round(input int a, input int p, input int o);
      keynum(a);
      keynum(p);
      if (OTP_EN) keynum(o);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_acc"}, bus.accNumber, 0);
      chk({tag, "_pin"}, bus.pin, 0);
      chk({tag, "_otp"}, bus.otp, 0);
      chk({tag, "_st"}, bus.state_o, 0);
      chk({tag, "_cv"}, bus.cred_valid, 0);
      chk({tag, "_err"}, bus.entry_error, 0);
      chk({tag, "_lk"}, bus.locked, 0);
   endtask

   initial begin
      int lk_cnt, kv, kc, ok, fl;
      rst_n = 1'b0;
      bus.key_valid = 0; bus.key_code = 0; bus.auth_ok = 0; bus.auth_fail = 0;
      mreset();
      #23;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Full credential round
      round(2178, 4, 9);
      key(9); key(10);
      chk("present_acc", bus.accNumber, 2178);
      chk("present_pin", bus.pin, 4);
      chk("present_state", bus.state_o, 4);
      key(12);

      // Account out of range, then recovery
      key(5); key(0); key(0); key(0); key(10);
      chk("acc_oor_state", bus.state_o, 1);
      key(11); keynum(2816);
      chk("acc2816", bus.accNumber, 2816);
      chk("acc2816_state", bus.state_o, 2);
      key(1); key(6); key(10);
      key(11); key(6); key(10);
      chk("pin6", bus.pin, 6);
      if (OTP_EN) keynum(3);
      key(10);          // empty-state ENTER in PRESENT is ignored
      cyc(0, 0, 1, 0);  // auth_ok clears fails
      key(12);
      key(10);          // ENTER in IDLE ignored

      // Three failed rounds -> lockout
      for (int r = 0; r < MAXT; r++) begin
         round(100 + r, 7, 1);
         cyc(0, 0, 0, 1);
      end
      lk_cnt = (bus.locked === 1'b1) ? 1 : 0;
      for (int i = 0; i < LOCK + 8; i++) begin
         cyc(1, $urandom_range(0, 15), 0, 0);
         if (bus.locked === 1'b1) lk_cnt++;
      end
      chk("lock_len", lk_cnt, LOCK);
      key(12); idle(2);

      // Simultaneous ok/fail counts as fail; later ok clears the counter
      round(1, 2, 3);
      cyc(0, 0, 1, 1);
      round(1, 2, 3);
      cyc(0, 0, 1, 0);
      key(12);
      for (int r = 0; r < MAXT - 1; r++) begin
         round(55, 1, 1);
         cyc(0, 0, 0, 1);
      end
      chk("no_lock_yet", bus.locked, 0);
      round(55, 1, 1);
      cyc(0, 0, 0, 1);
      chk("lock_again", bus.locked, 1);
      idle(LOCK + 2);

      // Async reset during PIN entry
      keynum(2178); key(4);
      chk("pre_rst_acc", bus.accNumber, 2178);
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      mreset();
      @(negedge clk);
      rst_n = 1'b1;
      round(2178, 4, 9);
      chk("final_otp", bus.otp, OTP_EN ? 9 : 0);
      key(12);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         kv = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0:       kc = 10;
            1:       kc = ($urandom_range(0, 3) == 0) ? 12 : 10;
            2:       kc = $urandom_range(11, 15);
            default: kc = $urandom_range(0, 9);
         endcase
         ok = ($urandom_range(0, 5) == 0);
         fl = ($urandom_range(0, 4) == 0);
         if (kv && kc == 12) begin ok = 0; fl = 0; end
         cyc(kv[0], kc, ok[0], fl[0]);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
